// File: rtl/umi_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// umi_cmd_arbiter_if
// Bundles the requester-side and downstream-side signals of the UMI command
// arbiter.
//   in_valid  [N]     requester i has a command beat
//   in_cmd    [N*CW]  requester i word at [i*CW +: CW]
//   in_eom    [N]     beat is the last of requester i's transaction
//   in_ready  [N]     beat of requester i accepted this cycle
//   out_valid         output register holds a beat
//   out_cmd   [CW]    registered command word
//   out_eom           registered eom of that beat
//   out_src   [NW]    requester index that issued the beat
//   out_ready         downstream accepts the beat
//   busy              a grant is locked for a multi-beat transaction
// Modports: slave = arbiter view, master = surrounding environment view.
// ---------------------------------------------------------------------------
interface umi_cmd_arbiter_if #(
    parameter int N  = 4,
    parameter int CW = 32
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    in_valid;
    logic [N*CW-1:0] in_cmd;
    logic [N-1:0]    in_eom;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [CW-1:0]   out_cmd;
    logic            out_eom;
    logic [NW-1:0]   out_src;
    logic            out_ready;
    logic            busy;

    modport slave (
        input  in_valid, in_cmd, in_eom, out_ready,
        output in_ready, out_valid, out_cmd, out_eom, out_src, busy
    );

    modport master (
        output in_valid, in_cmd, in_eom, out_ready,
        input  in_ready, out_valid, out_cmd, out_eom, out_src, busy
    );
endinterface

// File: rtl/umi_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// umi_cmd_arbiter
// Shares one UMI command channel between N requesters. Round-robin grant,
// held for a whole transaction until its eom beat is accepted, feeding a
// single registered valid/ready output stage.
// Ports:
//   clk     rising-edge clock
//   nreset  asynchronous active-low reset
//   bus     umi_cmd_arbiter_if.slave (requester inputs, downstream output)
// ---------------------------------------------------------------------------
module umi_cmd_arbiter #(
    parameter int N  = 4,
    parameter int CW = 32
) (
    input  logic             clk,
    input  logic             nreset,
    umi_cmd_arbiter_if.slave bus
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]    r_state;
    logic [NW-1:0] r_ptr;
    logic [NW-1:0] r_owner;
    logic          r_gap;       // bubble cycle right after a locked message ends
    logic          r_out_valid;
    logic [CW-1:0] r_out_cmd;
    logic          r_out_eom;
    logic [NW-1:0] r_out_src;

    logic          w_ld;
    logic          w_gnt_vld;
    logic [NW-1:0] w_gnt;
    logic [NW:0]   w_sum;
    logic [NW-1:0] w_idx;
    logic [N-1:0]  w_ready;
    logic          w_xfer;
    logic [CW-1:0] w_cmd;
    logic          w_eom;

    function automatic logic [NW-1:0] inc_mod(input logic [NW-1:0] v);
        if (v == NW'(N - 1)) return '0;
        return v + NW'(1);
    endfunction

    assign w_ld = ~r_out_valid | bus.out_ready;

    // Grant selection. The search runs from the farthest offset back to the
    // pointer so the last hit is the first valid requester at or after ptr.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_sum     = '0;
        w_idx     = '0;
        if (r_state == ST_LOCK) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_owner;
        end else if (!r_gap) begin
            for (int k = N - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_ptr} + (NW + 1)'(k);
                if (w_sum >= (NW + 1)'(N)) w_sum = w_sum - (NW + 1)'(N);
                w_idx = w_sum[NW-1:0];
                if (bus.in_valid[w_idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = w_idx;
                end
            end
        end
    end

    // in_ready is gated by nreset so nothing is accepted while reset is held.
    always_comb begin
        w_ready = '0;
        if (nreset && w_ld && w_gnt_vld) w_ready[w_gnt] = bus.in_valid[w_gnt];
    end

    always_comb begin
        w_cmd = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt == NW'(i)) w_cmd = bus.in_cmd[i*CW +: CW];
        end
    end

    assign w_xfer = |w_ready;
    assign w_eom  = bus.in_eom[w_gnt];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gap       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cmd   <= '0;
            r_out_eom   <= 1'b0;
            r_out_src   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            if (w_ld) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_cmd <= w_cmd;
                    r_out_eom <= w_eom;
                    r_out_src <= w_gnt;
                end
            end
            r_gap <= (r_state == ST_LOCK) && w_xfer && w_eom;
            if (w_xfer) begin
                if (w_eom) begin
                    r_state <= ST_IDLE;
                    r_ptr   <= inc_mod(w_gnt);
                end else if (r_state == ST_IDLE) begin
                    r_state <= ST_LOCK;
                    r_owner <= w_gnt;
                end
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_cmd   = r_out_cmd;
    assign bus.out_eom   = r_out_eom;
    assign bus.out_src   = r_out_src;
    assign bus.busy      = (r_state == ST_LOCK);
endmodule
